// File: rtl/gray_conv_pkg.sv
// -----------------------------------------------------------------------------
// gray_conv_pkg
// Shared types and constants for the Gray/Binary conversion arbiter and its
// converter core.
//   state_t  : arbiter sequencing states
//   MODE_*   : encoding of the per-request conversion direction
// -----------------------------------------------------------------------------
package gray_conv_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CONVERT = 2'd1,
      RESPOND = 2'd2
   } state_t;

   localparam logic MODE_G2B = 1'b0;
   localparam logic MODE_B2G = 1'b1;

endpackage

// File: rtl/gray_binary_converter_core.sv
// -----------------------------------------------------------------------------
// gray_binary_converter_core
// Purely combinational Gray<->Binary converter, shared by all requesters.
// Ports:
//   Mode_In   : MODE_G2B (0) = Gray->Binary, MODE_B2G (1) = Binary->Gray
//   Data_In   : word to convert
//   Data_Out  : converted word
// -----------------------------------------------------------------------------
module gray_binary_converter_core
   import gray_conv_pkg::*;
#(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  Mode_In,
   input  logic [DATA_WIDTH-1:0] Data_In,
   output logic [DATA_WIDTH-1:0] Data_Out
);

   // Each binary bit is the XOR of its Gray bit and the binary bit above it,
   // so the ripple runs from the MSB downward.
   function automatic logic [DATA_WIDTH-1:0] gray_to_bin(input logic [DATA_WIDTH-1:0] g);
      logic [DATA_WIDTH-1:0] b;
      b = '0;
      b[DATA_WIDTH-1] = g[DATA_WIDTH-1];
      for (int i = DATA_WIDTH - 2; i >= 0; i--) begin
         b[i] = g[i] ^ b[i+1];
      end
      return b;
   endfunction

   function automatic logic [DATA_WIDTH-1:0] bin_to_gray(input logic [DATA_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   always_comb begin
      Data_Out = '0;
      if (Mode_In == MODE_B2G) begin
         Data_Out = bin_to_gray(Data_In);
      end else begin
         Data_Out = gray_to_bin(Data_In);
      end
   end

endmodule

// File: rtl/gray_binary_conversion_arbiter.sv
// -----------------------------------------------------------------------------
// gray_binary_conversion_arbiter
// Round-robin arbiter sharing one Gray/Binary converter core between NUM_REQ
// requesters. One transaction at a time: accept, convert, respond.
//
// state   | meaning
// --------+------------------------------------------------------------------
// IDLE    | waiting for a request; winner gets a one-hot Req_Ready_Out strobe
// CONVERT | latched word runs through the core; result registered to Resp_*
// RESPOND | Resp_Valid_Out held until the consumer takes it
//
// Ports:
//   Clock_In        : system clock, rising edge
//   Reset_In        : synchronous, active-high reset
//   Req_Valid_In    : per-requester request valid
//   Req_Mode_In     : per-requester mode (0 = Gray->Binary, 1 = Binary->Gray)
//   Req_Data_In     : per-requester data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   Req_Ready_Out   : one-hot accept strobe (IDLE only)
//   Resp_Valid_Out  : response valid
//   Resp_Ready_In   : response consumer ready
//   Resp_Data_Out   : conversion result
//   Resp_Mode_Out   : mode of the returned transaction
//   Resp_Id_Out     : index of the served requester
// -----------------------------------------------------------------------------
module gray_binary_conversion_arbiter
   import gray_conv_pkg::*;
#(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 4,
   parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
   input  logic                          Clock_In,
   input  logic                          Reset_In,
   input  logic [NUM_REQ-1:0]            Req_Valid_In,
   input  logic [NUM_REQ-1:0]            Req_Mode_In,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] Req_Data_In,
   output logic [NUM_REQ-1:0]            Req_Ready_Out,
   output logic                          Resp_Valid_Out,
   input  logic                          Resp_Ready_In,
   output logic [DATA_WIDTH-1:0]         Resp_Data_Out,
   output logic                          Resp_Mode_Out,
   output logic [ID_WIDTH-1:0]           Resp_Id_Out
);

   state_t                state;
   state_t                next_state;

   logic [ID_WIDTH-1:0]   last_grant;
   logic [ID_WIDTH-1:0]   winner;
   logic                  any_valid;
   logic [NUM_REQ-1:0]    req_ready;

   logic [DATA_WIDTH-1:0] lat_data;
   logic                  lat_mode;
   logic [ID_WIDTH-1:0]   lat_id;
   logic [DATA_WIDTH-1:0] conv_out;

   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_data;
   logic                  resp_mode;
   logic [ID_WIDTH-1:0]   resp_id;

   // Search upward from last+1 with wrap. Walking the offsets from farthest
   // to nearest lets the nearest valid requester overwrite the result.
   function automatic logic [ID_WIDTH-1:0] rr_pick(
      input logic [NUM_REQ-1:0]  valid,
      input logic [ID_WIDTH-1:0] last
   );
      logic [ID_WIDTH-1:0] pick;
      int                  idx;
      pick = '0;
      for (int i = NUM_REQ; i >= 1; i--) begin
         idx = (int'(last) + i) % NUM_REQ;
         if (valid[idx]) begin
            pick = ID_WIDTH'(idx);
         end
      end
      return pick;
   endfunction

   assign any_valid = |Req_Valid_In;
   assign winner    = rr_pick(Req_Valid_In, last_grant);

   gray_binary_converter_core #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_core (
      .Mode_In  (lat_mode),
      .Data_In  (lat_data),
      .Data_Out (conv_out)
   );

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      req_ready  = '0;
      case (state)
         IDLE: begin
            if (any_valid) begin
               req_ready[winner] = 1'b1;
               next_state        = CONVERT;
            end
         end
         CONVERT: begin
            next_state = RESPOND;
         end
         RESPOND: begin
            if (resp_valid && Resp_Ready_In) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
      // No accept strobe while reset is being applied: nothing is latched.
      if (Reset_In) begin
         req_ready = '0;
      end
   end

   always_ff @(posedge Clock_In) begin
      if (Reset_In) begin
         last_grant <= ID_WIDTH'(NUM_REQ - 1);
         lat_data   <= '0;
         lat_mode   <= MODE_G2B;
         lat_id     <= '0;
         resp_valid <= 1'b0;
         resp_data  <= '0;
         resp_mode  <= MODE_G2B;
         resp_id    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  lat_data <= Req_Data_In[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
                  lat_mode <= Req_Mode_In[winner];
                  lat_id   <= winner;
               end
            end
            CONVERT: begin
               resp_data  <= conv_out;
               resp_mode  <= lat_mode;
               resp_id    <= lat_id;
               resp_valid <= 1'b1;
            end
            RESPOND: begin
               // Payload is left in place after the handshake.
               if (resp_valid && Resp_Ready_In) begin
                  resp_valid <= 1'b0;
                  last_grant <= resp_id;
               end
            end
            default: begin
               resp_valid <= 1'b0;
            end
         endcase
      end
   end

   assign Req_Ready_Out  = req_ready;
   assign Resp_Valid_Out = resp_valid;
   assign Resp_Data_Out  = resp_data;
   assign Resp_Mode_Out  = resp_mode;
   assign Resp_Id_Out    = resp_id;

endmodule

// File: tb/tb_gray_binary_conversion_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gray_binary_conversion_arbiter
// Self-checking bench: a negedge monitor predicts each grant with its own
// round-robin model, pushes the expected response to a queue and compares it
// when the DUT hands the response over. Directed sequences add timing checks.
// -----------------------------------------------------------------------------
module tb_gray_binary_conversion_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 4;
   localparam int ID_WIDTH   = 2;

   typedef struct packed {
      logic [1:0] id;
      logic       mode;
      logic [3:0] data;
   } exp_t;

   logic                          clk_sys;
   logic                          rst;
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_mode;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_ready;
   logic                          resp_valid;
   logic                          resp_ready;
   logic [DATA_WIDTH-1:0]         resp_data;
   logic                          resp_mode;
   logic [ID_WIDTH-1:0]           resp_id;

   int   n_vec = 0;
   int   n_err = 0;
   int   tb_last = NUM_REQ - 1;
   exp_t sb[$];
   int   grant_log[$];

   gray_binary_conversion_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .ID_WIDTH   (ID_WIDTH)
   ) dut (
      .Clock_In       (clk_sys),
      .Reset_In       (rst),
      .Req_Valid_In   (req_valid),
      .Req_Mode_In    (req_mode),
      .Req_Data_In    (req_data),
      .Req_Ready_Out  (req_ready),
      .Resp_Valid_Out (resp_valid),
      .Resp_Ready_In  (resp_ready),
      .Resp_Data_Out  (resp_data),
      .Resp_Mode_Out  (resp_mode),
      .Resp_Id_Out    (resp_id)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // Binary bit i is the parity of all Gray bits at or above i.
   function automatic logic [3:0] ref_g2b(input logic [3:0] g);
      logic [3:0] b;
      for (int i = 0; i < 4; i++) b[i] = ^(g >> i);
      return b;
   endfunction

   function automatic logic [3:0] ref_conv(input logic m, input logic [3:0] d);
      return m ? (d ^ {1'b0, d[3:1]}) : ref_g2b(d);
   endfunction

   function automatic int rr_model(input logic [3:0] v, input int last);
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (v[(last + i) % NUM_REQ]) return (last + i) % NUM_REQ;
      end
      return -1;
   endfunction

   // Monitor / scoreboard
   always @(negedge clk_sys) begin
      if (rst) begin
         sb.delete();
         tb_last = NUM_REQ - 1;
      end else begin
         if (req_ready != '0) begin
            int   w;
            int   act_idx;
            exp_t e;
            w = rr_model(req_valid, tb_last);
            check_eq("grant", {28'd0, req_ready}, (w < 0) ? 32'd0 : (32'd1 << w));
            act_idx = 0;
            for (int k = 0; k < NUM_REQ; k++) if (req_ready[k]) act_idx = k;
            grant_log.push_back(act_idx);
            if (w >= 0) begin
               e.id   = 2'(w);
               e.mode = req_mode[w];
               e.data = ref_conv(req_mode[w], req_data[w*4 +: 4]);
               sb.push_back(e);
               tb_last = w;
            end
         end
         if (resp_valid && resp_ready) begin
            if (sb.size() == 0) begin
               check_eq("resp_unexpected", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_eq("resp_id",   {30'd0, resp_id},   {30'd0, e.id});
               check_eq("resp_mode", {31'd0, resp_mode}, {31'd0, e.mode});
               check_eq("resp_data", {28'd0, resp_data}, {28'd0, e.data});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic apply_reset(input int cycles);
      tick();
      rst = 1'b1;
      repeat (cycles) tick();
      rst = 1'b0;
   endtask

   task automatic drive_req(input int id, input logic m, input logic [3:0] d);
      req_valid[id]        = 1'b1;
      req_mode[id]         = m;
      req_data[id*4 +: 4]  = d;
   endtask

   task automatic wait_accept(input int id, input string tag);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         @(negedge clk_sys);
         if (req_ready[id]) seen = 1'b1;
      end
      if (!seen) check_eq(tag, 32'd0, 32'd1);
   endtask

   task automatic drain(input string tag);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge clk_sys);
         if (sb.size() == 0 && !resp_valid) done = 1'b1;
      end
      if (!done) check_eq(tag, 32'd0, 32'd1);
   endtask

   task automatic send(input int id, input logic m, input logic [3:0] d);
      tick();
      drive_req(id, m, d);
      wait_accept(id, "accept_timeout");
      tick();
      req_valid[id] = 1'b0;
      drain("drain_timeout");
   endtask

   initial begin
      int exp_order[5];
      bit seen;

      rst        = 1'b1;
      req_valid  = '0;
      req_mode   = '0;
      req_data   = '0;
      resp_ready = 1'b1;

      // Reset values
      repeat (3) tick();
      @(negedge clk_sys);
      check_eq("rst_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("rst_data",  {28'd0, resp_data},  32'd0);
      check_eq("rst_mode",  {31'd0, resp_mode},  32'd0);
      check_eq("rst_id",    {30'd0, resp_id},    32'd0);
      check_eq("rst_ready", {28'd0, req_ready},  32'd0);

      // Requester 0, Gray->Binary 0xC: same-cycle strobe, response two edges later
      tick();
      rst = 1'b0;
      drive_req(0, 1'b0, 4'hC);
      @(negedge clk_sys);
      check_eq("dir0_ready", {28'd0, req_ready}, 32'h1);
      tick();
      req_valid[0] = 1'b0;
      @(negedge clk_sys);
      check_eq("dir0_convert_valid", {31'd0, resp_valid}, 32'd0);
      tick();
      @(negedge clk_sys);
      check_eq("dir0_valid", {31'd0, resp_valid}, 32'd1);
      check_eq("dir0_data",  {28'd0, resp_data},  32'h8);
      check_eq("dir0_id",    {30'd0, resp_id},    32'd0);
      check_eq("dir0_mode",  {31'd0, resp_mode},  32'd0);
      tick();
      @(negedge clk_sys);
      check_eq("dir0_done_valid", {31'd0, resp_valid}, 32'd0);

      // Requester 2, Binary->Gray 0x8
      tick();
      drive_req(2, 1'b1, 4'h8);
      @(negedge clk_sys);
      check_eq("dir2_ready", {28'd0, req_ready}, 32'h4);
      tick();
      req_valid[2] = 1'b0;
      tick();
      @(negedge clk_sys);
      check_eq("dir2_data", {28'd0, resp_data}, 32'hC);
      check_eq("dir2_id",   {30'd0, resp_id},   32'd2);
      drain("dir2_drain");

      // Round-robin with all requesters held valid
      apply_reset(2);
      grant_log.delete();
      req_data = 16'h935F;
      req_mode = 4'b1010;
      req_valid = 4'b1111;
      seen = 1'b0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk_sys);
         if (grant_log.size() >= 5) seen = 1'b1;
      end
      tick();
      req_valid = '0;
      check_eq("rr_grant_count", seen, 32'd1);
      exp_order = '{0, 1, 2, 3, 0};
      for (int i = 0; i < 5; i++) begin
         if (i < grant_log.size())
            check_eq($sformatf("rr_order%0d", i), grant_log[i], exp_order[i]);
      end
      drain("rr_drain");

      // Backpressure in RESPOND
      tick();
      resp_ready = 1'b0;
      drive_req(1, 1'b0, 4'h6);
      wait_accept(1, "bp_accept_timeout");
      tick();
      req_valid[1] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk_sys);
         if (resp_valid) seen = 1'b1;
      end
      check_eq("bp_resp_seen", seen, 32'd1);
      tick();
      drive_req(3, 1'b1, 4'h2);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk_sys);
         check_eq("bp_hold_valid", {31'd0, resp_valid}, 32'd1);
         check_eq("bp_hold_data",  {28'd0, resp_data},  32'h4);
         check_eq("bp_no_ready",   {28'd0, req_ready},  32'd0);
         tick();
      end
      resp_ready = 1'b1;
      @(negedge clk_sys);
      check_eq("bp_hs_valid", {31'd0, resp_valid}, 32'd1);
      tick();
      @(negedge clk_sys);
      check_eq("bp_idle_valid", {31'd0, resp_valid}, 32'd0);
      check_eq("bp_idle_ready", {28'd0, req_ready},  32'h8);
      tick();
      req_valid[3] = 1'b0;
      drain("bp_drain");

      // Reset while in CONVERT
      tick();
      drive_req(1, 1'b1, 4'hA);
      wait_accept(1, "mid_accept_timeout");
      tick();
      req_valid[1] = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_sys);
         check_eq("mid_valid", {31'd0, resp_valid}, 32'd0);
         check_eq("mid_data",  {28'd0, resp_data},  32'd0);
         check_eq("mid_id",    {30'd0, resp_id},    32'd0);
         check_eq("mid_mode",  {31'd0, resp_mode},  32'd0);
         tick();
      end
      drive_req(3, 1'b0, 4'h1);
      drive_req(0, 1'b0, 4'h7);
      @(negedge clk_sys);
      check_eq("mid_prio_ready", {28'd0, req_ready}, 32'h1);
      tick();
      req_valid[0] = 1'b0;
      wait_accept(3, "mid_r3_timeout");
      tick();
      req_valid[3] = 1'b0;
      drain("mid_drain");

      // Every 4-bit value in both modes from random requesters
      for (int m = 0; m < 2; m++) begin
         for (int v = 0; v < 16; v++) begin
            send(int'($urandom_range(0, NUM_REQ - 1)), m[0], 4'(v));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, %0d miscompares so far", n_err);
      $fatal(1);
   end

endmodule
